// File: rtl/fht_frame_ctrl.sv
// fht_frame_ctrl: frames ADC samples into the four FHT banks,
// kicks off the transform and unloads result rows with backpressure.
module fht_frame_ctrl #(
  parameter int D_BIT     = 16,
  parameter int A_BIT     = 8,
  parameter int ADC_WIDTH = 12,
  parameter int RD_LAT    = 2
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic [ADC_WIDTH-1:0] iADC_DATA,
  input  logic                 iADC_VALID,
  output logic                 oADC_READY,
  output logic [3:0]           oWE,
  output logic [D_BIT-1:0]     oDATA,
  output logic [A_BIT-1:0]     oADDR_WR,
  output logic                 oSTART,
  input  logic                 iRDY,
  output logic [A_BIT-1:0]     oADDR_RD,
  input  logic [D_BIT-1:0]     iRAM_DATA_0,
  input  logic [D_BIT-1:0]     iRAM_DATA_1,
  input  logic [D_BIT-1:0]     iRAM_DATA_2,
  input  logic [D_BIT-1:0]     iRAM_DATA_3,
  output logic [D_BIT-1:0]     oOUT_DATA_0,
  output logic [D_BIT-1:0]     oOUT_DATA_1,
  output logic [D_BIT-1:0]     oOUT_DATA_2,
  output logic [D_BIT-1:0]     oOUT_DATA_3,
  output logic                 oOUT_VALID,
  input  logic                 iOUT_READY,
  input  logic                 iBIT_REV,
  input  logic                 iABORT,
  output logic                 oBUSY
);

  localparam int SH = D_BIT - ADC_WIDTH - 1;
  localparam int LW = $clog2(RD_LAT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_UNLOAD
  } state_t;

  state_t               state_q, state_d;
  logic [A_BIT+1:0]     k_q, k_d;
  logic [A_BIT-1:0]     r_q, r_d;
  logic [LW-1:0]        lat_q, lat_d;
  logic                 rev_q, rev_d;
  logic                 abort_q, abort_d;
  logic [3:0]           we_q, we_d;
  logic [D_BIT-1:0]     data_q, data_d;
  logic [A_BIT-1:0]     addr_wr_q, addr_wr_d;
  logic                 start_q, start_d;
  logic [A_BIT-1:0]     addr_rd_q, addr_rd_d;
  logic [D_BIT-1:0]     out0_q, out0_d;
  logic [D_BIT-1:0]     out1_q, out1_d;
  logic [D_BIT-1:0]     out2_q, out2_d;
  logic [D_BIT-1:0]     out3_q, out3_d;
  logic                 valid_q, valid_d;

  logic                 ready;
  logic                 accept;
  logic                 abort_any;
  logic [D_BIT-1:0]     ext;
  logic [D_BIT-1:0]     wdata;
  logic [A_BIT-1:0]     r_nxt;

  // Row counter to RAM row, optionally bit-reversed.
  function automatic logic [A_BIT-1:0] row_addr(
    input logic [A_BIT-1:0] rr,
    input logic             rev
  );
    logic [A_BIT-1:0] b;
    for (int i = 0; i < A_BIT; i++) begin
      b[i] = rr[A_BIT-1-i];
    end
    return rev ? b : rr;
  endfunction

  // Sample acceptance and fixed-point write formatting.
  always_comb begin
    ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    accept = iADC_VALID && ready &&
             !(iABORT && (state_q == S_LOAD));
    ext = {{(D_BIT-ADC_WIDTH){iADC_DATA[ADC_WIDTH-1]}}, iADC_DATA};
    wdata = ext << SH;
    abort_any = abort_q || iABORT;
    r_nxt = r_q + 1'b1;
  end

  // Next-state and next-output computation for the frame FSM.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    r_d       = r_q;
    lat_d     = lat_q;
    rev_d     = rev_q;
    abort_d   = abort_q;
    we_d      = '0;
    data_d    = data_q;
    addr_wr_d = addr_wr_q;
    start_d   = 1'b0;
    addr_rd_d = addr_rd_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    out3_d    = out3_q;
    valid_d   = valid_q;

    if (accept) begin
      we_d      = 4'b0001 << k_q[1:0];
      data_d    = wdata;
      addr_wr_d = k_q[A_BIT+1:2];
    end

    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (accept) begin
          state_d = S_LOAD;
          k_d     = k_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (iABORT) begin
          state_d = S_IDLE;
          k_d     = '0;
        end else if (accept) begin
          if (k_q == '1) begin
            state_d = S_START;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_START: begin
        start_d = 1'b1;
        abort_d = abort_any;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        abort_d = abort_any;
        if (!iRDY) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        abort_d = abort_any;
        if (iRDY) begin
          abort_d = 1'b0;
          if (abort_any) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_UNLOAD;
            r_d       = '0;
            rev_d     = iBIT_REV;
            addr_rd_d = '0;
            lat_d     = LW'(RD_LAT);
            valid_d   = 1'b0;
          end
        end
      end
      S_UNLOAD: begin
        if (iABORT) begin
          state_d   = S_IDLE;
          r_d       = '0;
          lat_d     = '0;
          valid_d   = 1'b0;
          addr_rd_d = '0;
        end else if (valid_q) begin
          if (iOUT_READY) begin
            valid_d = 1'b0;
            if (r_q == '1) begin
              state_d   = S_IDLE;
              r_d       = '0;
              addr_rd_d = '0;
            end else begin
              r_d       = r_nxt;
              addr_rd_d = row_addr(r_nxt, rev_q);
              lat_d     = LW'(RD_LAT);
            end
          end
        end else if (lat_q == '0) begin
          out0_d  = iRAM_DATA_0;
          out1_d  = iRAM_DATA_1;
          out2_d  = iRAM_DATA_2;
          out3_d  = iRAM_DATA_3;
          valid_d = 1'b1;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      r_q       <= '0;
      lat_q     <= '0;
      rev_q     <= 1'b0;
      abort_q   <= 1'b0;
      we_q      <= '0;
      data_q    <= '0;
      addr_wr_q <= '0;
      start_q   <= 1'b0;
      addr_rd_q <= '0;
      out0_q    <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      out3_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      r_q       <= r_d;
      lat_q     <= lat_d;
      rev_q     <= rev_d;
      abort_q   <= abort_d;
      we_q      <= we_d;
      data_q    <= data_d;
      addr_wr_q <= addr_wr_d;
      start_q   <= start_d;
      addr_rd_q <= addr_rd_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      out3_q    <= out3_d;
      valid_q   <= valid_d;
    end
  end

  assign oADC_READY  = ready;
  assign oBUSY       = (state_q != S_IDLE);
  assign oWE         = we_q;
  assign oDATA       = data_q;
  assign oADDR_WR    = addr_wr_q;
  assign oSTART      = start_q;
  assign oADDR_RD    = addr_rd_q;
  assign oOUT_DATA_0 = out0_q;
  assign oOUT_DATA_1 = out1_q;
  assign oOUT_DATA_2 = out2_q;
  assign oOUT_DATA_3 = out3_q;
  assign oOUT_VALID  = valid_q;

endmodule

// File: tb/tb_fht_frame_ctrl.sv
// tb_fht_frame_ctrl: directed bench for fht_frame_ctrl with
// A_BIT=3 (8 rows, 32-sample frames) and a 2-cycle RAM model.
module tb_fht_frame_ctrl;

  logic        clk = 1'b0;
  logic        iRESET;
  logic [11:0] iADC_DATA;
  logic        iADC_VALID;
  logic        oADC_READY;
  logic [3:0]  oWE;
  logic [15:0] oDATA;
  logic [2:0]  oADDR_WR;
  logic        oSTART;
  logic        iRDY;
  logic [2:0]  oADDR_RD;
  logic [15:0] ram0, ram1, ram2, ram3;
  logic [15:0] oOUT_DATA_0, oOUT_DATA_1;
  logic [15:0] oOUT_DATA_2, oOUT_DATA_3;
  logic        oOUT_VALID;
  logic        iOUT_READY;
  logic        iBIT_REV;
  logic        iABORT;
  logic        oBUSY;

  int n_cmp = 0;
  int n_err = 0;

  int we_ones = 0;
  int start_cnt = 0;
  int valid_cyc = 0;
  int hs_cnt = 0;
  logic [2:0]  hs_addr [64];
  logic [15:0] hs_d0 [64];
  logic [15:0] hs_d3 [64];

  logic [2:0] p1, p2;

  fht_frame_ctrl #(
    .D_BIT(16), .A_BIT(3), .ADC_WIDTH(12), .RD_LAT(2)
  ) dut (
    .iCLK(clk),
    .iRESET(iRESET),
    .iADC_DATA(iADC_DATA),
    .iADC_VALID(iADC_VALID),
    .oADC_READY(oADC_READY),
    .oWE(oWE),
    .oDATA(oDATA),
    .oADDR_WR(oADDR_WR),
    .oSTART(oSTART),
    .iRDY(iRDY),
    .oADDR_RD(oADDR_RD),
    .iRAM_DATA_0(ram0),
    .iRAM_DATA_1(ram1),
    .iRAM_DATA_2(ram2),
    .iRAM_DATA_3(ram3),
    .oOUT_DATA_0(oOUT_DATA_0),
    .oOUT_DATA_1(oOUT_DATA_1),
    .oOUT_DATA_2(oOUT_DATA_2),
    .oOUT_DATA_3(oOUT_DATA_3),
    .oOUT_VALID(oOUT_VALID),
    .iOUT_READY(iOUT_READY),
    .iBIT_REV(iBIT_REV),
    .iABORT(iABORT),
    .oBUSY(oBUSY)
  );

  always #5 clk = ~clk;

  // RAM with two-cycle read latency; bank n row a holds (n+1)<<12 | a.
  always @(posedge clk) begin
    p1 <= oADDR_RD;
    p2 <= p1;
  end
  assign ram0 = 16'h1000 | {13'd0, p2};
  assign ram1 = 16'h2000 | {13'd0, p2};
  assign ram2 = 16'h3000 | {13'd0, p2};
  assign ram3 = 16'h4000 | {13'd0, p2};

  // Activity counters and handshake log.
  always @(posedge clk) begin
    we_ones <= we_ones + $countones(oWE);
    if (oSTART) start_cnt <= start_cnt + 1;
    if (oOUT_VALID) valid_cyc <= valid_cyc + 1;
    if (oOUT_VALID && iOUT_READY && hs_cnt < 64) begin
      hs_addr[hs_cnt] <= oADDR_RD;
      hs_d0[hs_cnt]   <= oOUT_DATA_0;
      hs_d3[hs_cnt]   <= oOUT_DATA_3;
      hs_cnt <= hs_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] samp(input int k);
    if (k == 0) return 12'h800;
    if (k == 5) return 12'h001;
    return 12'(k * 37 + 3);
  endfunction

  function automatic logic [15:0] fmt(input logic [11:0] s);
    return {s[11], s, 3'b000};
  endfunction

  // Offer n back-to-back samples, optional one-cycle gap before gap_at.
  task automatic load(input int n, input int gap_at);
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) begin
        iADC_VALID = 1'b0;
        step();
        chk("gap_no_we", oWE, 0);
      end
      iADC_DATA  = samp(k);
      iADC_VALID = 1'b1;
      step();
      chk("we_bank", oWE, 32'(4'b0001 << (k % 4)));
      chk("we_row", oADDR_WR, k / 4);
      chk("we_data", oDATA, fmt(samp(k)));
      if (k == 0) chk("s0_c000", oDATA, 16'hC000);
      if (k == 5) begin
        chk("s5_we", oWE, 4'b0010);
        chk("s5_row", oADDR_WR, 1);
        chk("s5_data", oDATA, 16'h0008);
      end
      chk("ready", oADC_READY, (k == 31) ? 0 : 1);
    end
    iADC_VALID = 1'b0;
  endtask

  initial begin
    int b, w0, s0, v0, n;
    iRESET = 1'b1;
    iADC_DATA = '0;
    iADC_VALID = 1'b0;
    iRDY = 1'b1;
    iOUT_READY = 1'b1;
    iBIT_REV = 1'b0;
    iABORT = 1'b0;
    step();
    step();
    chk("rst_we", oWE, 0);
    chk("rst_data", oDATA, 0);
    chk("rst_start", oSTART, 0);
    chk("rst_valid", oOUT_VALID, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_ready", oADC_READY, 1);
    chk("rst_addr_rd", oADDR_RD, 0);
    iRESET = 1'b0;
    step();

    // Frame 1: load, start, stale iRDY, bit-reversed unload.
    w0 = we_ones;
    s0 = start_cnt;
    load(32, -1);
    step();
    chk("start_pulse", oSTART, 1);
    chk("start_we0", oWE, 0);
    chk("we_pulses", we_ones - w0, 32);
    step();
    chk("start_one", oSTART, 0);
    step();
    step();
    chk("stale_rdy_busy", oBUSY, 1);
    chk("stale_rdy_novalid", oOUT_VALID, 0);
    iRDY = 1'b0;
    iBIT_REV = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("rdy_lo_novalid", oOUT_VALID, 0);
    chk("start_count1", start_cnt - s0, 1);
    b = hs_cnt;
    iRDY = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!oOUT_VALID && n < 50);
    chk("first_valid_lat", n, 4);
    n = 0;
    while (hs_cnt < b + 8 && n < 100) begin
      step();
      n++;
    end
    chk("rev_rows", hs_cnt - b, 8);
    chk("rev_idle", oBUSY, 0);
    chk("rev_valid_off", oOUT_VALID, 0);
    begin
      logic [2:0] rv [8];
      rv = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      for (int i = 0; i < 8; i++) begin
        chk("rev_addr", hs_addr[b+i], rv[i]);
        chk("rev_d0", hs_d0[b+i], 16'h1000 | 16'(rv[i]));
        chk("rev_d3", hs_d3[b+i], 16'h4000 | 16'(rv[i]));
      end
    end

    // Frame 2: gap in samples, natural order, backpressure on row 3.
    load(32, 7);
    step();
    chk("start2", oSTART, 1);
    iRDY = 1'b0;
    iBIT_REV = 1'b0;
    step();
    step();
    b = hs_cnt;
    iRDY = 1'b1;
    n = 0;
    while (!(oOUT_VALID && hs_cnt == b + 3) && n < 100) begin
      step();
      n++;
    end
    iOUT_READY = 1'b0;
    chk("bp_found", oOUT_VALID && hs_cnt == b + 3, 1);
    chk("bp_d0", oOUT_DATA_0, 16'h1003);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", oOUT_VALID, 1);
      chk("bp_hold_d0", oOUT_DATA_0, 16'h1003);
      chk("bp_hold_d3", oOUT_DATA_3, 16'h4003);
    end
    chk("bp_no_hs", hs_cnt - b, 3);
    iOUT_READY = 1'b1;
    step();
    chk("bp_release", hs_cnt - b, 4);
    n = 0;
    while (hs_cnt < b + 8 && n < 100) begin
      step();
      n++;
    end
    chk("nat_rows", hs_cnt - b, 8);
    chk("nat_idle", oBUSY, 0);
    for (int i = 0; i < 8; i++) begin
      chk("nat_addr", hs_addr[b+i], i);
      chk("nat_d0", hs_d0[b+i], 16'h1000 + i);
    end

    // Abort at sample 10, then a clean frame from row 0 bank 0.
    w0 = we_ones;
    s0 = start_cnt;
    load(10, -1);
    iADC_DATA = 12'h123;
    iADC_VALID = 1'b1;
    iABORT = 1'b1;
    step();
    iADC_VALID = 1'b0;
    iABORT = 1'b0;
    chk("abort_idle", oBUSY, 0);
    chk("abort_no_we", oWE, 0);
    for (int i = 0; i < 4; i++) step();
    chk("abort_writes", we_ones - w0, 10);
    chk("abort_no_start", start_cnt - s0, 0);

    // Abort while the transform runs: no unload.
    v0 = valid_cyc;
    load(32, -1);
    step();
    chk("start3", oSTART, 1);
    iRDY = 1'b0;
    iABORT = 1'b1;
    step();
    iABORT = 1'b0;
    step();
    step();
    chk("fht_abort_wait", oBUSY, 1);
    iRDY = 1'b1;
    step();
    chk("fht_abort_idle", oBUSY, 0);
    for (int i = 0; i < 10; i++) step();
    chk("fht_abort_novalid", valid_cyc - v0, 0);

    // Reset in the middle of an unload.
    load(32, -1);
    step();
    iRDY = 1'b0;
    step();
    iRDY = 1'b1;
    iOUT_READY = 1'b0;
    n = 0;
    while (!oOUT_VALID && n < 50) begin
      step();
      n++;
    end
    chk("mid_valid", oOUT_VALID, 1);
    chk("mid_d0", oOUT_DATA_0, 16'h1000);
    w0 = we_ones;
    s0 = start_cnt;
    iRESET = 1'b1;
    step();
    iRESET = 1'b0;
    chk("mrst_we", oWE, 0);
    chk("mrst_data", oDATA, 0);
    chk("mrst_addr_wr", oADDR_WR, 0);
    chk("mrst_start", oSTART, 0);
    chk("mrst_addr_rd", oADDR_RD, 0);
    chk("mrst_d0", oOUT_DATA_0, 0);
    chk("mrst_d1", oOUT_DATA_1, 0);
    chk("mrst_d2", oOUT_DATA_2, 0);
    chk("mrst_d3", oOUT_DATA_3, 0);
    chk("mrst_valid", oOUT_VALID, 0);
    chk("mrst_busy", oBUSY, 0);
    chk("mrst_ready", oADC_READY, 1);
    for (int i = 0; i < 5; i++) step();
    chk("mrst_no_we", we_ones - w0, 0);
    chk("mrst_no_start", start_cnt - s0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
